// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Command sequencer in front of the shared AND/OR/ADD/SUB ALU.
//               Runs single-pass ops, SLT (from a SUB) and MUL (shift-add
//               over WIDTH ALU additions). Command and response use
//               valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [2:0] c_CMD_AND = 3'b000;
    localparam logic [2:0] c_CMD_OR  = 3'b001;
    localparam logic [2:0] c_CMD_ADD = 3'b010;
    localparam logic [2:0] c_CMD_MUL = 3'b011;
    localparam logic [2:0] c_CMD_SUB = 3'b110;
    localparam logic [2:0] c_CMD_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_cmd;
    logic [WIDTH-1:0] r_a;     // operand A, also the MUL multiplicand
    logic [WIDTH-1:0] r_b;     // operand B, also the MUL multiplier
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_nxt;
    logic             w_ovf;
    logic             w_slt;
    logic             w_last;

    // Next multiplier bit index; its wrap on the final iteration is never used.
    assign w_nxt  = r_cnt + CNT_W'(1);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    // Signed less-than from the SUB result, corrected for two's-complement overflow.
    assign w_ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) & (alu_r[WIDTH-1] != r_a[WIDTH-1]);
    assign w_slt  = alu_r[WIDTH-1] ^ w_ovf;

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cmd      <= 3'b000;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_op     <= c_CMD_ADD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cmd     <= req_cmd;
                        r_a       <= req_a;
                        r_b       <= req_b;
                        req_ready <= 1'b0;
                        case (req_cmd)
                            c_CMD_AND, c_CMD_OR, c_CMD_ADD, c_CMD_SUB: begin
                                alu_x   <= req_a;
                                alu_y   <= req_b;
                                alu_op  <= req_cmd;
                                r_state <= S_EXEC;
                            end
                            c_CMD_SLT: begin
                                alu_x   <= req_a;
                                alu_y   <= req_b;
                                alu_op  <= c_CMD_SUB;
                                r_state <= S_EXEC;
                            end
                            c_CMD_MUL: begin
                                // alu_x doubles as the running partial-product accumulator.
                                r_cnt   <= '0;
                                alu_x   <= '0;
                                alu_y   <= req_b[0] ? req_a : '0;
                                alu_op  <= c_CMD_ADD;
                                r_state <= S_MUL;
                            end
                            default: begin
                                // Illegal command: answer immediately, ALU untouched.
                                rsp_result <= '0;
                                rsp_zero   <= 1'b1;
                                rsp_err    <= 1'b1;
                                r_state    <= S_DONE;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    rsp_result <= (r_cmd == c_CMD_SLT) ? {{(WIDTH-1){1'b0}}, w_slt} : alu_r;
                    rsp_err    <= 1'b0;
                    r_state    <= S_DONE;
                end
                S_MUL: begin
                    if (w_last) begin
                        // Low WIDTH bits of the product; upper half is dropped.
                        rsp_result <= alu_r;
                        rsp_err    <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        alu_x <= alu_r;
                        alu_y <= r_b[w_nxt] ? (r_a << w_nxt) : '0;
                        r_cnt <= w_nxt;
                    end
                end
                default: begin
                    // First DONE cycle raises rsp_valid; then wait for the consumer.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_zero  <= (rsp_result == '0);
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Command sequencer in front of the shared 32-bit ALU (AND/OR/ADD/SUB datapath, op codes 000/001/010/110) for the RISC calculator.
- Accepts one calculator command at a time over a valid/ready handshake and drives the ALU operand and op inputs from registers.
- Single-pass ops take one ALU cycle. MUL is built from 32 iterative ALU ADDs (shift-add). SLT is derived from an ALU SUB.
- Returns result, zero flag and error flag over a valid/ready response handshake.

Parameters:
- WIDTH, 32, operand/result width. MUL iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  controller can accept a command
- req_cmd  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL, 100/101 illegal
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- alu_x  out  WIDTH  ALU operand x (registered)
- alu_y  out  WIDTH  ALU operand y (registered)
- alu_op  out  3  ALU op (registered)
- alu_r  in  WIDTH  ALU result, combinational from alu_x/alu_y/alu_op
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  WIDTH  final result
- rsp_zero  out  1  rsp_result == 0
- rsp_err  out  1  illegal command

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_zero=0; rsp_err=0.
  - alu_x=0, alu_y=0, alu_op=010, iteration count=0.
  - Asserting reset mid-command abandons the command with no response.
- Handshakes: a transfer occurs on a clock edge where valid&ready=1.
  - req_ready=1 only in IDLE.
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
- States: IDLE, EXEC, MUL, DONE.
- IDLE, on accept:
  - Latch cmd, a, b.
  - AND/OR/ADD/SUB: alu_x=a, alu_y=b, alu_op=cmd; go to EXEC.
  - SLT: alu_x=a, alu_y=b, alu_op=110; go to EXEC.
  - MUL: acc=0, mcand=a, mplier=b, cnt=0, alu_x=0, alu_y=(b[0] ? a : 0), alu_op=010; go to MUL.
  - Illegal: rsp_result=0, rsp_zero=1, rsp_err=1; go to DONE directly, with no ALU cycle.
- EXEC (1 cycle): capture alu_r.
  - For SLT, result = {WIDTH-1 zeros, r[W-1] XOR ovf}, where ovf = (a[W-1]!=b[W-1]) & (r[W-1]!=a[W-1]).
  - rsp_err=0; go to DONE.
- MUL (WIDTH cycles, cnt 0..WIDTH-1):
  - Each cycle: acc <= alu_r; next alu_x = alu_r; next alu_y = mplier[cnt+1] ? (mcand << (cnt+1)) : 0.
  - When cnt==WIDTH-1: result = alu_r (low WIDTH bits of product; the upper half is discarded, no overflow flag); go to DONE.
  - Otherwise cnt increments. Carry out of the ALU add is ignored (modulo 2^WIDTH).
- DONE:
  - rsp_valid=1; rsp_zero=(rsp_result==0).
  - On rsp_ready=1, go to IDLE; req_ready returns to 1 in the following cycle. There is no same-cycle back-to-back accept.
- Latency from accept edge to rsp_valid:
  - Single-pass ops and SLT: 2 cycles.
  - MUL: WIDTH+1 cycles.
  - Illegal: 1 cycle.
- alu_x/alu_y/alu_op hold their last values in IDLE and DONE.
- req_valid while busy is ignored and not lost by the controller; the requester must hold it.

Test Plan:
- After reset release: req_ready=1, rsp_valid=0, alu_op=010. Then ADD a=0xFFFFFFFF, b=1 -> rsp_valid 2 cycles after accept, rsp_result=0, rsp_zero=1, rsp_err=0.
- SUB a=5, b=7 -> 0xFFFFFFFE, zero=0. SLT a=0x80000000, b=1 -> 1. SLT a=0x7FFFFFFF, b=0xFFFFFFFF -> 0 (overflow case).
- MUL a=1234, b=5678 -> 7006652 after 33 cycles. MUL a=0x10000, b=0x10000 -> 0, zero=1. MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> 1.
- cmd=100 -> rsp_err=1, rsp_result=0, rsp_valid 1 cycle after accept, no change on alu_* outputs.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_* stable, req_ready=0, new req_valid not accepted. Then rsp_ready=1 -> IDLE, next command accepted the cycle after.
- Assert resetn=0 at MUL iteration 15 -> all outputs at reset values immediately. After release, a new ADD 3+4 returns 7.
